// File: rtl/rob_commit_unit_if.sv
// ROB read-side and free-list release bundle for rob_commit_unit.
interface rob_commit_unit_if #(
  parameter int P_ADDR_WIDTH = 7,
  parameter int INSTR_COUNT  = 2
);
  localparam int PW = INSTR_COUNT * P_ADDR_WIDTH;

  logic [INSTR_COUNT-1:0] rob_valid;
  logic [INSTR_COUNT-1:0] rob_exec;
  logic [PW-1:0]          rob_ppdst;
  logic [INSTR_COUNT-1:0] rob_pop;
  logic [INSTR_COUNT-1:0] fl_valid;
  logic [PW-1:0]          fl_ppdst;
  logic [INSTR_COUNT-1:0] fl_take;

  modport master (
    output rob_valid,
    output rob_exec,
    output rob_ppdst,
    output fl_take,
    input  rob_pop,
    input  fl_valid,
    input  fl_ppdst
  );

  modport slave (
    input  rob_valid,
    input  rob_exec,
    input  rob_ppdst,
    input  fl_take,
    output rob_pop,
    output fl_valid,
    output fl_ppdst
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order ROB retirement feeding a PPdst release FIFO,
// with a drain sequence that signals when ROB and FIFO are empty.
module rob_commit_unit #(
  parameter int ROB_DEPTH      = 128,
  parameter int P_ADDR_WIDTH   = 7,
  parameter int INSTR_COUNT    = 2,
  parameter int REL_FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [31:0]      retired_cnt,
  rob_commit_unit_if.slave bus
);
  localparam int IC = INSTR_COUNT;
  localparam int PA = P_ADDR_WIDTH;
  localparam int PW =
    (REL_FIFO_DEPTH > 1) ? $clog2(REL_FIFO_DEPTH) : 1;
  localparam int OW = $clog2(REL_FIFO_DEPTH + 1);
  localparam logic [OW-1:0] FULL = OW'(REL_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PA-1:0] r_mem [REL_FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;
  logic [31:0]   r_retired;

  logic [OW-1:0] w_ncand;
  logic [OW-1:0] w_room;
  logic [OW-1:0] w_n;
  logic [OW-1:0] w_ntake;
  logic          w_run;
  logic          w_trun;
  logic          w_block;
  logic          w_done;
  logic [IC-1:0] w_pop;
  logic [IC-1:0] w_flv;

  // Leading run of executed entries only.
  always_comb begin
    w_ncand = '0;
    w_run   = 1'b1;
    for (int i = 0; i < IC; i++) begin
      w_run   = w_run & bus.rob_valid[i]
              & bus.rob_exec[i];
      w_ncand = w_ncand + OW'(w_run);
    end
  end

  // Room uses registered occupancy; takes are not credited.
  assign w_room  = FULL - r_occ;
  assign w_block = !rst_n || halt
                || (r_state == S_DONE);

  always_comb begin
    w_n = '0;
    if (!w_block) begin
      w_n = (w_ncand < w_room) ? w_ncand : w_room;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < IC; i++) begin
      w_pop[i] = (OW'(i) < w_n);
    end
  end

  always_comb begin
    w_flv = '0;
    for (int k = 0; k < IC; k++) begin
      w_flv[k] = (r_occ > OW'(k));
    end
  end

  // Excess take bits beyond the valid thermometer are dropped.
  always_comb begin
    w_ntake = '0;
    w_trun  = 1'b1;
    for (int k = 0; k < IC; k++) begin
      w_trun  = w_trun & bus.fl_take[k] & w_flv[k];
      w_ntake = w_ntake + OW'(w_trun);
    end
  end

  always_comb begin
    bus.fl_ppdst = '0;
    for (int k = 0; k < IC; k++) begin
      bus.fl_ppdst[k*PA +: PA] =
        r_mem[r_rd_ptr + PW'(k)];
    end
  end

  assign bus.rob_pop  = w_pop;
  assign bus.fl_valid = w_flv;
  assign retired_cnt  = r_retired;
  assign drain_done   = w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < REL_FIFO_DEPTH; j++) begin
        r_mem[j] <= '0;
      end
    end else begin
      for (int i = 0; i < IC; i++) begin
        if (w_pop[i]) begin
          r_mem[r_wr_ptr + PW'(i)] <=
            bus.rob_ppdst[i*PA +: PA];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_retired <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + PW'(w_n);
      r_rd_ptr  <= r_rd_ptr + PW'(w_ntake);
      r_occ     <= r_occ + w_n - w_ntake;
      r_retired <= r_retired + 32'(w_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (drain_req) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.rob_valid[0] && r_occ == '0
            && w_n == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  a_take_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
    ((bus.fl_take & ~w_flv) == '0)
    && ((bus.fl_take & (bus.fl_take + IC'(1)))
        == '0));

  a_rob_bound: assert property (
    @(posedge clk) disable iff (!rst_n)
    $countones(bus.rob_valid) <= ROB_DEPTH);

endmodule
